// File: rtl/pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// RAW-hazard scoreboard and forwarding-select generator for the pipelined
// MIPS core. Every in-flight register-writing instruction is tracked from EX
// (position 1) to WB (position DEPTH) in a shift register. Each cycle the
// instruction sitting in ID is checked against those producers. The block
// then decides either to stall the pipeline, or to pick the downstream
// position that each source operand is forwarded from.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, stall_cycles counts the clock edges on which stall was
//   high. The count saturates at all-ones and is cleared only by reset.
//   When undefined, no counter logic is built and stall_cycles is tied to 0.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   id_valid             ID holds a real instruction
//   id_rs, id_rt         source register addresses
//   id_uses_rs/rt        the matching source is actually read
//   id_rd, id_regwrite   destination register and its write enable
//   id_is_load           the ID instruction is a load
//   flush                taken branch: kill the ID instruction
//   stall                combinational: freeze PC/IF-ID, bubble into EX
//   ex_valid             registered: EX holds an issued instruction
//   ex_fwd_a, ex_fwd_b   registered forward selects (0 = register file,
//                        k = forward from position k)
//   stall_cycles         stall-cycle performance counter
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int SEL_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [SEL_W-1:0]  ex_fwd_a,
  output logic [SEL_W-1:0]  ex_fwd_b,
  output logic [31:0]       stall_cycles
);

  // Scoreboard entries. Index p is the producer currently at position p.
  logic [DEPTH:1]             valid_q, valid_d;
  logic [DEPTH:1][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH:1]             is_load_q, is_load_d;

  logic             ex_valid_q, ex_valid_d;
  logic [SEL_W-1:0] ex_fwd_a_q, ex_fwd_a_d;
  logic [SEL_W-1:0] ex_fwd_b_q, ex_fwd_b_d;

  logic             need_a, need_b;
  logic             haz_a, haz_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             issue;

  // Resolves one source operand. The result is {hazard, select}. The loop
  // walks from the oldest position to the youngest, so the youngest match
  // overwrites any older one and alone decides the result. A producer in
  // the last position writes the register file this cycle, and that write
  // lands before the read, so no forwarding is needed.
  function automatic logic [SEL_W:0] resolve(
    input logic [REG_AW-1:0]             src,
    input logic                          needed,
    input logic [DEPTH:1]                v,
    input logic [DEPTH:1][REG_AW-1:0]    rd,
    input logic [DEPTH:1]                ld
  );
    logic             haz;
    logic [SEL_W-1:0] sel;
    int               q;
    int               r;
    haz = 1'b0;
    sel = '0;
    q   = 0;
    r   = 0;
    if (needed) begin
      for (int p = DEPTH; p >= 1; p--) begin
        if (v[p] && (rd[p] == src)) begin
          if (p == DEPTH) begin
            haz = 1'b0;
            sel = '0;
          end else begin
            q = p + 1;
            r = ld[p] ? LOAD_READY : ALU_READY;
            if (q >= r) begin
              haz = 1'b0;
              sel = SEL_W'(q);
            end else begin
              haz = 1'b1;
              sel = '0;
            end
          end
        end
      end
    end
    return {haz, sel};
  endfunction

  // Hazard and forward-select decision for the instruction in ID.
  always_comb begin
    need_a         = id_valid & id_uses_rs & (id_rs != '0);
    need_b         = id_valid & id_uses_rt & (id_rt != '0);
    {haz_a, sel_a} = resolve(id_rs, need_a, valid_q, rd_q, is_load_q);
    {haz_b, sel_b} = resolve(id_rt, need_b, valid_q, rd_q, is_load_q);
    stall          = ~flush & (haz_a | haz_b);
    issue          = id_valid & ~stall & ~flush;
  end

  // Next state. The entries shift one position toward WB, and position 1
  // takes the issuing producer or a bubble. Writes to r0 are not tracked
  // because r0 never causes a hazard.
  always_comb begin
    valid_d   = '0;
    rd_d      = '0;
    is_load_d = '0;
    for (int p = DEPTH; p >= 2; p--) begin
      valid_d[p]   = valid_q[p-1];
      rd_d[p]      = rd_q[p-1];
      is_load_d[p] = is_load_q[p-1];
    end
    valid_d[1]   = issue & id_regwrite & (id_rd != '0);
    rd_d[1]      = id_rd;
    is_load_d[1] = id_is_load;

    ex_valid_d = issue;
    ex_fwd_a_d = issue ? sel_a : '0;
    ex_fwd_b_d = issue ? sel_b : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      rd_q       <= '0;
      is_load_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_fwd_a_q <= '0;
      ex_fwd_b_q <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      ex_valid_q <= ex_valid_d;
      ex_fwd_a_q <= ex_fwd_a_d;
      ex_fwd_b_q <= ex_fwd_b_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_fwd_a = ex_fwd_a_q;
  assign ex_fwd_b = ex_fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // The counter saturates so that a long run cannot wrap back to small values.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Self-checking bench for pipe_hazard_scoreboard with default parameters.
// A table of per-cycle ID-stage records drives the scoreboard through the
// load-use, ALU forwarding, youngest-match, flush and write-before-read
// cases. The combinational stall is compared before each edge. The expected
// EX-stage outputs are queued and then compared after the edge. A hand-written
// sequence then checks an asynchronous reset taken in the middle of a stall.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_regwrite, id_is_load, flush;
  logic        stall, ex_valid;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  bit cnt_en;

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       fl;
    logic       es;
    logic       ev;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  typedef struct {
    string      name;
    logic       ev;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  pipe_hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_fwd_a     (ex_fwd_a),
    .ex_fwd_b     (ex_fwd_b),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic v, logic [4:0] rs, logic urs,
                              logic [4:0] rt, logic urt, logic [4:0] rd,
                              logic rw, logic ld, logic fl, logic es,
                              logic ev, logic [1:0] fa, logic [1:0] fb);
    vec_t r;
    r.name = n; r.v = v; r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt;
    r.rd = rd; r.rw = rw; r.ld = ld; r.fl = fl; r.es = es; r.ev = ev;
    r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t t);
    id_valid    = t.v;
    id_rs       = t.rs;
    id_uses_rs  = t.urs;
    id_rt       = t.rt;
    id_uses_rt  = t.urt;
    id_rd       = t.rd;
    id_regwrite = t.rw;
    id_is_load  = t.ld;
    flush       = t.fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkEx();
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      checkOutput({e.name, "/ex_valid"}, {31'd0, ex_valid}, {31'd0, e.ev});
      checkOutput({e.name, "/ex_fwd_a"}, {30'd0, ex_fwd_a}, {30'd0, e.fa});
      checkOutput({e.name, "/ex_fwd_b"}, {30'd0, ex_fwd_b}, {30'd0, e.fb});
    end
  endtask

  // One ID-stage cycle: drive, check stall before the edge, queue EX expectation,
  // then compare the registered outputs after the edge.
  task automatic runCycle(input vec_t t);
    exp_t e;
    @(negedge clk);
    applyStimulus(t);
    #1;
    checkOutput({t.name, "/stall"}, {31'd0, stall}, {31'd0, t.es});
    e.name = t.name; e.ev = t.ev; e.fa = t.fa; e.fb = t.fb;
    sbq.push_back(e);
    @(posedge clk);
    if (cnt_en && t.es && exp_cnt != -1) exp_cnt++;
    #1;
    checkEx();
  endtask

  initial begin
    vec_t idle;
`ifdef HAZARD_PERF_CNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //        name           v  rs urs rt urt rd rw ld fl  es ev fa fb
    tbl.push_back(mk("lw_r1",       1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lu_stall",    1, 1, 1, 3, 1, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("lu_fwd3",     1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk("add_r1",      1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("sub_fwd2",    1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 1, 2, 2));
    tbl.push_back(mk("add_r1_b",    1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("or_r1",       1, 7, 1, 8, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("and_young",   1, 1, 1, 0, 1, 5, 1, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk("lw_r1_b",     1, 9, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("flush_dep",   1, 1, 1, 3, 1, 2, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("bubble_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("no_flush_ent",1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lw_r7",       1, 10,1, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("bubble_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("bubble_c",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wb_rf_path",  1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lw_r9",       1, 12,1, 0, 0, 9, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("invalid_dep", 0, 9, 1, 9, 1, 2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lw9_at_p2",   1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(mk("lw_r11",      1, 13,1, 0, 0, 11,1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("unused_rt",   1, 0, 1, 11,0, 3, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lw_r6",       1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lu_rt_stall", 1, 0, 0, 6, 1, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("lu_rt_fwd3",  1, 0, 0, 6, 1, 2, 1, 0, 0, 0, 1, 0, 3));

    applyStimulus(idle);
    rst_n = 1'b0;
    #12;
    checkOutput("reset/stall",        {31'd0, stall},    32'd0);
    checkOutput("reset/ex_valid",     {31'd0, ex_valid}, 32'd0);
    checkOutput("reset/ex_fwd_a",     {30'd0, ex_fwd_a}, 32'd0);
    checkOutput("reset/ex_fwd_b",     {30'd0, ex_fwd_b}, 32'd0);
    checkOutput("reset/stall_cycles", stall_cycles,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) runCycle(tbl[i]);

    checkOutput("table/stall_cycles", stall_cycles, exp_cnt);

    // Asynchronous reset taken while a load-use stall is active.
    runCycle(mk("rs_add_r1", 1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    runCycle(mk("rs_lw_r3",  1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 1, 2, 0));
    @(negedge clk);
    applyStimulus(mk("rs_dep", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("mid/stall",        {31'd0, stall},    32'd1);
    checkOutput("mid/ex_fwd_a",     {30'd0, ex_fwd_a}, 32'd2);
    checkOutput("mid/stall_cycles", stall_cycles,      exp_cnt);
    #1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checkOutput("async/stall",        {31'd0, stall},    32'd0);
    checkOutput("async/ex_valid",     {31'd0, ex_valid}, 32'd0);
    checkOutput("async/ex_fwd_a",     {30'd0, ex_fwd_a}, 32'd0);
    checkOutput("async/ex_fwd_b",     {30'd0, ex_fwd_b}, 32'd0);
    checkOutput("async/stall_cycles", stall_cycles,      32'd0);
    @(posedge clk);
    #1;
    checkOutput("held/ex_valid", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // The load that caused the stall was wiped, so the dependent issues from the register file.
    runCycle(mk("post_rst_dep", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0));
    checkOutput("final/stall_cycles", stall_cycles, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
